// File: rtl/tinyqv_instr_aligner_if.sv
// Fetch-beat and instruction handshake bundle for tinyqv_instr_aligner.
// The slave modport is the aligner; the master modport is the fetch unit plus consumer.
interface tinyqv_instr_aligner_if #(
  parameter int unsigned DEPTH_HW = 8,
  parameter int unsigned FETCH_HW = 2
);
  localparam int unsigned LVL_W = $clog2(DEPTH_HW) + 1;

  logic                    flush;
  logic [22:0]             pc_in;
  logic                    fetch_valid;
  logic                    fetch_ready;
  logic [16*FETCH_HW-1:0]  fetch_data;
  logic                    instr_valid;
  logic                    instr_ready;
  logic [31:0]             instr;
  logic [2:1]              instr_len;
  logic [22:0]             instr_pc;
  logic [LVL_W-1:0]        level;

  modport master (
    output flush, pc_in, fetch_valid, fetch_data, instr_ready,
    input  fetch_ready, instr_valid, instr, instr_len, instr_pc, level
  );

  modport slave (
    input  flush, pc_in, fetch_valid, fetch_data, instr_ready,
    output fetch_ready, instr_valid, instr, instr_len, instr_pc, level
  );
endinterface

// File: rtl/tinyqv_instr_aligner.sv
// Instruction aligner: queues 16-bit halfwords from fetch beats in a circular
// buffer and presents complete 16/32-bit RISC-V instructions with their PC.
// Optional macro TINYQV_ALIGNER_BYPASS_EN: present an instruction straight from
// the incoming beat when the queue is empty (combinational fetch->instr path).
module tinyqv_instr_aligner #(
  parameter int unsigned DEPTH_HW = 8,
  parameter int unsigned FETCH_HW = 2
) (
  input logic                   clk,
  input logic                   rstn,
  tinyqv_instr_aligner_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH_HW);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned PC_W  = 23;
  localparam int unsigned CNT_W = 2;
  localparam logic [LVL_W-1:0] READY_MAX = LVL_W'(DEPTH_HW - FETCH_HW);

  logic [15:0]      mem [DEPTH_HW];
  logic [PTR_W-1:0] rd_ptr, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             skip_q, skip_d;

  logic             accept;
  logic [15:0]      in_hw [FETCH_HW];
  logic [CNT_W-1:0] in_cnt;
  logic             byp;
  logic [15:0]      h0, h1;
  logic [LVL_W-1:0] avail;
  logic             is32;
  logic             pop;
  logic [CNT_W-1:0] pop_cnt;
  logic [CNT_W-1:0] wr_shift;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_adv;
  logic [15:0]      wr_hw [FETCH_HW];

  assign bus.fetch_ready = !bus.flush && (level_q <= READY_MAX);
  assign accept          = bus.fetch_valid && bus.fetch_ready;
  assign bus.level       = level_q;
  assign bus.instr_pc    = pc_q;

  // Split the beat into halfwords; a pending skip drops the low halfword.
  always_comb begin
    for (int i = 0; i < FETCH_HW; i++) begin
      in_hw[i] = bus.fetch_data[16*i +: 16];
    end
    in_cnt = CNT_W'(FETCH_HW);
    if (skip_q) begin
      in_hw[0] = bus.fetch_data[16*(FETCH_HW-1) +: 16];
      in_cnt   = CNT_W'(1);
    end
  end

  // Select the head halfwords: from the buffer, or from the beat when bypassing.
  always_comb begin
    h0    = mem[rd_ptr];
    h1    = mem[rd_ptr + PTR_W'(1)];
    avail = level_q;
    byp   = 1'b0;
`ifdef TINYQV_ALIGNER_BYPASS_EN
    if ((level_q == '0) && accept) begin
      byp   = 1'b1;
      h0    = in_hw[0];
      h1    = in_hw[FETCH_HW-1];
      avail = LVL_W'(in_cnt);
    end
`endif
  end

  // Decode the head and drive the instruction side of the handshake.
  always_comb begin
    is32            = (h0[1:0] == 2'b11);
    bus.instr_valid = !bus.flush &&
                      ((avail >= LVL_W'(2)) || ((avail == LVL_W'(1)) && !is32));
    bus.instr       = is32 ? {h1, h0} : {16'h0000, h0};
    bus.instr_len   = is32 ? 2'b10 : 2'b01;
    pop             = bus.instr_valid && bus.instr_ready;
    pop_cnt         = pop ? (is32 ? CNT_W'(2) : CNT_W'(1)) : CNT_W'(0);
  end

  // Work out which incoming halfwords get stored and how far each pointer moves.
  always_comb begin
    wr_shift = byp ? pop_cnt : CNT_W'(0);
    wr_cnt   = accept ? (in_cnt - wr_shift) : CNT_W'(0);
    rd_adv   = byp ? CNT_W'(0) : pop_cnt;
    for (int i = 0; i < FETCH_HW; i++) begin
      wr_hw[i] = in_hw[i];
    end
    if (wr_shift == CNT_W'(1)) begin
      wr_hw[0] = in_hw[FETCH_HW-1];
    end
  end

  // Next-state for pointers, level, PC and skip; flush overrides push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr + PTR_W'(rd_adv);
    wr_ptr_d = wr_ptr + PTR_W'(wr_cnt);
    level_d  = level_q + LVL_W'(wr_cnt) - LVL_W'(rd_adv);
    pc_d     = pc_q + PC_W'(pop_cnt);
    skip_d   = accept ? 1'b0 : skip_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      pc_d     = bus.pc_in;
      skip_d   = (FETCH_HW == 2) && bus.pc_in[0];
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
      pc_q    <= '0;
      skip_q  <= 1'b0;
    end else begin
      rd_ptr  <= rd_ptr_d;
      wr_ptr  <= wr_ptr_d;
      level_q <= level_d;
      pc_q    <= pc_d;
      skip_q  <= skip_d;
    end
  end

  // Halfword storage; contents are meaningless until level says otherwise.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_HW; i++) begin
      if (CNT_W'(i) < wr_cnt) begin
        mem[wr_ptr + PTR_W'(i)] <= wr_hw[i];
      end
    end
  end
endmodule

// File: doc/tinyqv_instr_aligner.md
TINYQV_INSTR_ALIGNER -- requirements
Module: tinyqv_instr_aligner

Interface
REQ-001 SHALL have parameter DEPTH_HW, default 8, meaning queue capacity in 16-bit halfwords; legal values are powers of 2 and at least 4.
REQ-002 SHALL have parameter FETCH_HW, default 2, meaning halfwords per fetch beat; legal values are 1 and 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1 bit: discard queue contents and restart at pc_in.
REQ-006 SHALL have port pc_in, input, 23 bits: restart address bits [23:1], sampled when flush is high.
REQ-007 SHALL have port fetch_valid, input, 1 bit: fetch_data is valid.
REQ-008 SHALL have port fetch_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-009 SHALL have port fetch_data, input, 16*FETCH_HW bits: halfwords, lowest address in bits [15:0].
REQ-010 SHALL have port instr_valid, output, 1 bit: a complete instruction is presented.
REQ-011 SHALL have port instr_ready, input, 1 bit: the consumer takes the instruction.
REQ-012 SHALL have port instr, output, 32 bits: the instruction; a 16-bit instruction is zero-extended.
REQ-013 SHALL have port instr_len, output, bits [2:1]: 2'b10 means 32-bit, 2'b01 means 16-bit.
REQ-014 SHALL have port instr_pc, output, 23 bits: address bits [23:1] of the presented instruction.
REQ-015 SHALL have port level, output, $clog2(DEPTH_HW)+1 bits: count of halfwords held.

Function
REQ-016 SHALL hold halfwords in a circular buffer, with read and write pointers wrapping modulo DEPTH_HW.
REQ-017 SHALL drive fetch_ready = !flush && (level <= DEPTH_HW-FETCH_HW); a beat is accepted when fetch_valid && fetch_ready.
REQ-018 SHALL treat a head halfword h0 with h0[1:0]==2'b11 as a 32-bit instruction {h1,h0}, valid only when level>=2; any other h0 is a 16-bit instruction {16'h0,h0}, valid when level>=1.
REQ-019 SHALL drive instr_valid low while flush is high; instr, instr_len and instr_pc are don't-care while instr_valid is low.
REQ-020 SHALL pop on instr_valid && instr_ready: level decreases by 1 (16-bit) or 2 (32-bit) halfwords, and instr_pc increases by the same amount, modulo 2^23.
REQ-021 SHALL hold instr, instr_len and instr_pc stable while instr_valid && !instr_ready, unless flush is asserted.
REQ-022 SHALL apply a push and a pop in the same cycle together: the new level is level + FETCH_HW - popped halfwords.
REQ-023 SHALL present a 32-bit instruction that straddles two beats only after both beats are accepted.
REQ-024 SHALL, at a clock edge with flush high, set level to 0, set both pointers to 0, load instr_pc from pc_in, and set skip = pc_in[0] && FETCH_HW==2; flush overrides any simultaneous push or pop.
REQ-025 SHALL, when skip is set, write only halfword [31:16] of the next accepted beat (level increases by 1) and then clear skip.
REQ-026 SHALL, without bypass, present an instruction no earlier than the cycle after the edge that accepted its last halfword.

Reset
REQ-027 SHALL, while rstn is low, immediately force level=0, pointers=0, instr_pc=0, skip=0, instr_valid=0 and fetch_ready=1, independent of clk.
REQ-028 SHALL lose any partially assembled instruction when reset is asserted mid-operation; operation resumes on the first clk edge after rstn goes high.

Configuration
REQ-029 SHALL, when TINYQV_ALIGNER_BYPASS_EN is defined, drive instr_valid in the same cycle when level is 0 and the accepted beat (after skip) holds a complete instruction; if instr_ready is also high, that instruction is not stored and only the remaining halfwords are written.
REQ-030 SHALL, when TINYQV_ALIGNER_BYPASS_EN is undefined, have no combinational path from fetch_* to instr_*, and the latency of REQ-026 applies.

Verification (FETCH_HW=2, DEPTH_HW=8 unless stated)
REQ-031 SHALL cover: flush with pc_in=0, then push 0x00000013 -> next cycle instr_valid=1, instr=0x00000013, instr_len=2'b10, instr_pc=0.
REQ-032 SHALL cover: flush with pc_in=0, push 0x45054501, instr_ready=1 -> 0x00004501 at instr_pc 0, then 0x00004505 at instr_pc 1, then level=0.
REQ-033 SHALL cover: push 0x00134501, then 0xFFFF0000 -> 0x4501 with len 2'b01, then 0x00000013 at instr_pc 1 only after the second beat; level=1 afterwards.
REQ-034 SHALL cover: flush with pc_in=0x000081, push 0x4505AAAA -> only 0x00004505 is delivered, at instr_pc 0x000081, with level=1 before the pop.
REQ-035 SHALL cover: instr_ready=0, push four beats of 0x00000013 -> level=8, fetch_ready=0; one 32-bit pop -> level=6, fetch_ready=1.
REQ-036 SHALL cover: rstn driven low with level=5 and no clk edge -> instr_valid=0, level=0, fetch_ready=1 immediately.
